// File: rtl/sobel_edge_mapper.sv
// sobel_edge_mapper
// Clears an edge-map BRAM, then streams one grayscale frame through a 3x3
// Sobel operator and writes one 2-bit edge flag per interior pixel.
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   start           - level request to process one frame (sampled in IDLE)
//   threshold       - gradient magnitude threshold, latched when start is taken
//   in_pixel/in_valid/in_ready - raster-order pixel stream
//   bram_addr/bram_wdata/bram_we - edge-map write port (addr = y*W + x)
//   edge_count      - number of edge (2'b01) writes in the current frame
//   done            - frame edge map complete, held until start drops
module sobel_edge_mapper #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [11:0]                                threshold,
  input  logic [7:0]                                 in_pixel,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]    bram_addr,
  output logic [1:0]                                 bram_wdata,
  output logic                                       bram_we,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]  edge_count,
  output logic                                       done
);
  localparam int IMG_SIZE = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW = $clog2(IMG_SIZE);
  localparam int CW = $clog2(IMG_SIZE + 1);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

  // Weighted 1-2-1 sum of three pixels; at most 1020, so 11 bits never overflow.
  function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    wsum = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  // Magnitude of an 11-bit signed gradient (range is +/-1020, so no overflow).
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    if (v[10]) begin
      abs11 = $unsigned(-v);
    end else begin
      abs11 = $unsigned(v);
    end
  endfunction

  state_t            state_r, next_state_s;
  logic [11:0]       thr_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [AW-1:0]     clr_r;
  logic              in_ready_r;
  logic [7:0]        lb_prev_r [0:IMG_WIDTH-1];   // row y-1
  logic [7:0]        lb_old_r  [0:IMG_WIDTH-1];   // row y-2
  logic [7:0]        win_r [0:2][0:2];            // [row oldest first][col oldest first]
  logic              win_v_r;
  logic [AW-1:0]     win_addr_r;
  logic              mag_v_r;
  logic              edge_r;
  logic [AW-1:0]     mag_addr_r;
  logic              bram_we_r;
  logic [AW-1:0]     bram_addr_r;
  logic [1:0]        bram_wdata_r;
  logic [CW-1:0]     edge_count_r;
  logic              done_r;

  logic              accept_s;
  logic              last_col_s;
  logic              last_row_s;
  logic [YW-1:0]     ym1_s;
  logic [AW-1:0]     win_addr_s;
  logic signed [10:0] gx_s;
  logic signed [10:0] gy_s;
  logic [11:0]       mag_s;

  assign accept_s   = in_valid && in_ready_r && (state_r == STREAM);
  assign last_col_s = (x_r == XW'(IMG_WIDTH - 1));
  assign last_row_s = (y_r == YW'(IMG_HEIGHT - 1));
  assign ym1_s      = y_r - YW'(1);
  // Centre of the window completed by the pixel at (x_r, y_r) is (x_r-1, y_r-1).
  assign win_addr_s = AW'(ym1_s) * AW'(IMG_WIDTH) + AW'(x_r) - AW'(1);

  assign gx_s  = $signed(wsum(win_r[0][2], win_r[1][2], win_r[2][2]) - wsum(win_r[0][0], win_r[1][0], win_r[2][0]));
  assign gy_s  = $signed(wsum(win_r[2][0], win_r[2][1], win_r[2][2]) - wsum(win_r[0][0], win_r[0][1], win_r[0][2]));
  assign mag_s = {1'b0, abs11(gx_s)} + {1'b0, abs11(gy_s)};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; STREAM ends once every pixel is taken and the write pipe has drained.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (start) next_state_s = CLEAR; else next_state_s = IDLE;
      CLEAR:   if (clr_r == AW'(IMG_SIZE - 1)) next_state_s = STREAM; else next_state_s = CLEAR;
      STREAM:  if (!in_ready_r && !win_v_r && !mag_v_r) next_state_s = DONE; else next_state_s = STREAM;
      DONE:    if (!start) next_state_s = IDLE; else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // Frame control: threshold latch, clear counter, raster position and in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_r      <= 12'd0;
      x_r        <= '0;
      y_r        <= '0;
      clr_r      <= '0;
      in_ready_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            thr_r <= threshold;
            x_r   <= '0;
            y_r   <= '0;
            clr_r <= '0;
          end
        end
        CLEAR: begin
          clr_r <= clr_r + AW'(1);
          if (clr_r == AW'(IMG_SIZE - 1)) in_ready_r <= 1'b1;
        end
        STREAM: begin
          if (accept_s) begin
            if (last_col_s) begin
              x_r <= '0;
              y_r <= y_r + YW'(1);
              if (last_row_s) in_ready_r <= 1'b0;
            end else begin
              x_r <= x_r + XW'(1);
            end
          end
        end
        default: in_ready_r <= 1'b0;
      endcase
    end
  end

  // Row buffers and 3x3 window; contents are qualified by the pipeline valids, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_old_r[x_r]  <= lb_prev_r[x_r];
      lb_prev_r[x_r] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= win_r[r][1];
        win_r[r][1] <= win_r[r][2];
      end
      win_r[0][2] <= lb_old_r[x_r];
      win_r[1][2] <= lb_prev_r[x_r];
      win_r[2][2] <= in_pixel;
    end
  end

  // Two-stage result pipeline: window valid, then magnitude compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_v_r    <= 1'b0;
      win_addr_r <= '0;
      mag_v_r    <= 1'b0;
      edge_r     <= 1'b0;
      mag_addr_r <= '0;
    end else begin
      // x>=2 and y>=2 guarantees a full window from one row band, never across the wrap.
      win_v_r    <= accept_s && (x_r >= XW'(2)) && (y_r >= YW'(2));
      win_addr_r <= win_addr_s;
      mag_v_r    <= win_v_r;
      edge_r     <= (mag_s >= thr_r);
      mag_addr_r <= win_addr_r;
    end
  end

  // Registered BRAM write port, edge counter and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_we_r    <= 1'b0;
      bram_addr_r  <= '0;
      bram_wdata_r <= 2'b00;
      edge_count_r <= '0;
      done_r       <= 1'b0;
    end else begin
      done_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          bram_we_r <= 1'b0;
          if (start) edge_count_r <= '0;
        end
        CLEAR: begin
          bram_we_r    <= 1'b1;
          bram_addr_r  <= clr_r;
          bram_wdata_r <= 2'b00;
        end
        STREAM: begin
          bram_we_r <= mag_v_r;
          if (mag_v_r) begin
            bram_addr_r  <= mag_addr_r;
            bram_wdata_r <= {1'b0, edge_r};
            edge_count_r <= edge_count_r + CW'(edge_r);
          end
        end
        default: bram_we_r <= 1'b0;
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign bram_we    = bram_we_r;
  assign bram_addr  = bram_addr_r;
  assign bram_wdata = bram_wdata_r;
  assign edge_count = edge_count_r;
  assign done       = done_r;

endmodule

// File: tb/tb_sobel_edge_mapper.sv
// Directed bench for sobel_edge_mapper on an 8x6 frame: clear phase, edge maps,
// write latency, in_valid gaps, mid-frame reset and DONE handshake.
module tb_sobel_edge_mapper;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] threshold = 12'd0;
  logic [7:0]  in_pixel = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  bram_addr;
  logic [1:0]  bram_wdata;
  logic        bram_we;
  logic [5:0]  edge_count;
  logic        done;

  sobel_edge_mapper #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .edge_count(edge_count), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] img [N];
  logic [1:0] mem [N];
  logic [1:0] exp_map [N];
  int wr_cnt, clr_bad, stream_wr, stream_ones, border_wr, wr9_cyc, last_wr_cyc, acc18_cyc;

  function automatic bit is_border(input int a);
    int x = a % W;
    int y = a / W;
    return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // BRAM model and write classifier: the first N writes of a frame are the clear pass.
  always @(negedge clk) begin
    if (bram_we) begin
      if (int'(bram_addr) < N) mem[bram_addr] = bram_wdata;
      if (wr_cnt < N) begin
        if ((int'(bram_addr) != wr_cnt) || (bram_wdata != 2'b00)) clr_bad++;
      end else begin
        stream_wr++;
        if (bram_wdata == 2'b01) stream_ones++;
        if (is_border(int'(bram_addr))) border_wr++;
        if ((bram_addr == 6'd9) && (wr9_cyc < 0)) wr9_cyc = cyc;
        last_wr_cyc = cyc;
      end
      wr_cnt++;
    end
  end

  // kind 0: all zero, 1: vertical step at column 4, 2: uniform 255
  task automatic load_image(input int kind);
    for (int a = 0; a < N; a++) begin
      int x = a % W;
      case (kind)
        0:       img[a] = 8'd0;
        1:       img[a] = (x >= 4) ? 8'd255 : 8'd0;
        default: img[a] = 8'd255;
      endcase
      if (is_border(a))     exp_map[a] = 2'b00;
      else if (kind == 0)   exp_map[a] = 2'b00;
      else if (kind == 1)   exp_map[a] = ((x == 3) || (x == 4)) ? 2'b01 : 2'b00;
      else                  exp_map[a] = 2'b01;
    end
  endtask

  task automatic run_frame(input string tag, input logic [11:0] thr, input bit toggle,
                           input int abort_at, input int exp_ones);
    int i;
    int budget;
    int mism;
    bit acc;
    wr_cnt = 0; clr_bad = 0; stream_wr = 0; stream_ones = 0; border_wr = 0;
    wr9_cyc = -1; last_wr_cyc = -1; acc18_cyc = -1;
    for (int a = 0; a < N; a++) mem[a] = 2'b11;
    @(negedge clk);
    threshold = thr;
    start = 1'b1;
    @(negedge clk);
    threshold = ~thr;  // must be ignored: already latched
    i = 0;
    budget = 0;
    while ((i < N) && (budget < 1000)) begin
      in_valid = toggle ? (budget % 2 == 0) : 1'b1;
      in_pixel = img[i];
      acc = in_valid && in_ready;
      if (acc && (i == 18)) acc18_cyc = cyc + 1;
      @(negedge clk);
      if (acc) i++;
      budget++;
      if ((abort_at > 0) && (i == abort_at)) break;
    end
    in_valid = 1'b0;
    if (abort_at > 0) begin
      chk({tag, "_abort_point"}, i, abort_at);
      return;
    end
    chk({tag, "_all_accepted"}, i, N);
    chk({tag, "_in_ready_drop"}, int'(in_ready), 0);
    budget = 0;
    while (!done && (budget < 100)) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_done_seen"}, int'(done), 1);
    chk({tag, "_done_after_last_write"}, cyc - last_wr_cyc, 1);
    chk({tag, "_latency_pix22"}, wr9_cyc - acc18_cyc, 2);
    repeat (2) @(negedge clk);
    chk({tag, "_done_held"}, int'(done), 1);
    chk({tag, "_edge_count"}, int'(edge_count), exp_ones);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clear"}, int'(done), 0);
    chk({tag, "_edge_count_kept"}, int'(edge_count), exp_ones);
    chk({tag, "_clear_writes_bad"}, clr_bad, 0);
    chk({tag, "_stream_writes"}, stream_wr, (W - 2) * (H - 2));
    chk({tag, "_stream_ones"}, stream_ones, exp_ones);
    chk({tag, "_border_writes"}, border_wr, 0);
    mism = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== exp_map[a]) mism++;
    chk({tag, "_map_mismatches"}, mism, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_bram_we"}, int'(bram_we), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_bram_addr"}, int'(bram_addr), 0);
    chk({tag, "_bram_wdata"}, int'(bram_wdata), 0);
    chk({tag, "_edge_count"}, int'(edge_count), 0);
  endtask

  initial begin
    int saved;
    wr_cnt = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load_image(0);
    run_frame("zero", 12'd1, 1'b0, 0, 0);

    load_image(1);
    run_frame("step", 12'd100, 1'b0, 0, 8);
    run_frame("step_gaps", 12'd100, 1'b1, 0, 8);

    run_frame("abort", 12'd100, 1'b0, 20, 8);
    saved = wr_cnt;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_no_writes", wr_cnt, saved);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("restart", 12'd100, 1'b0, 0, 8);

    load_image(2);
    run_frame("uniform", 12'd0, 1'b0, 0, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
